// File: rtl/master_port_pkg.sv
// Shared bus package: state encoding, field widths and
// helpers used by the master port and the slave-side blocks.
package master_port_pkg;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 8;
    localparam int BURST_W     = 13;
    localparam int SPLIT_BEATS = 8;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        HANDSHAKE,
        ADDR,
        WDATA,
        RWAIT,
        RDATA,
        SPLIT,
        DONE
    } state_t;

    // A single transfer is always its own last beat.
    function automatic logic last_beat(
        input logic              burst,
        input logic [ADDR_W-1:0] cnt,
        input logic [ADDR_W-1:0] len
    );
        return !burst || (cnt == len);
    endfunction

endpackage

// File: rtl/master_shift_reg.sv
// Parameterised LSB-first shift register, usable as PISO
// (ser_out) or SIPO (par_next holds the value after this shift).
module master_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    input  logic         ser_in,
    output logic         ser_out,
    output logic [W-1:0] par_next
);

    logic [W-1:0] q;

    assign par_next = {ser_in, q[W-1:1]};
    assign ser_out  = q[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= par_next;
        end
    end

endmodule

// File: rtl/master_port.sv
// Serial bus master: handshake, serial address/burst, write
// data beats, read data beats and slave split handling.
module master_port
    import master_port_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              burst_en,
    input  logic [ADDR_W-1:0] burst_len,
    input  logic              s_ready,
    input  logic              s_valid,
    input  logic              rx_data,
    input  logic              split_enable,
    output logic              m_valid,
    output logic              m_ready,
    output logic              read_enable,
    output logic              write_enable,
    output logic              tx_address,
    output logic              tx_data,
    output logic              tx_burst,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wdata_req,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] D_PRE  = CNT_W'(DATA_W - 2);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BURST_W - 1);

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    burst_cnt;
    logic                burst_win;
    logic [ADDR_W-1:0]   beat_cnt;
    logic [ADDR_W-1:0]   burst_len_q;
    logic                burst_en_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wbeat;
    logic                last_b;
    logic                start;

    logic                a_ser;
    logic                b_ser;
    logic                w_ser;
    logic                w_load;
    logic [DATA_W-1:0]   w_din;
    logic [DATA_W-1:0]   rx_next;
    logic [ADDR_W-1:0]   a_next_unused;
    logic [BURST_W-1:0]  b_next_unused;
    logic [DATA_W-1:0]   w_next_unused;
    logic                rx_ser_unused;

    assign start  = (state == IDLE) && req;
    assign last_b = last_beat(burst_en_q, beat_cnt, burst_len_q);

    // Write data reloads: request latch, next beat, or replay after a split.
    assign w_load = start
                  || ((state == WDATA) && (bit_cnt == D_LAST) && !last_b)
                  || ((state == SPLIT) && !split_enable && wr_q);
    assign w_din  = (state == SPLIT) ? wbeat : wdata;

    assign tx_address = (state == ADDR) & a_ser;
    assign tx_data    = (state == WDATA) & w_ser;
    assign tx_burst   = burst_win & b_ser;

    master_shift_reg #(.W(ADDR_W)) u_addr_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .din      (addr),
        .shift    (state == ADDR),
        .ser_in   (1'b0),
        .ser_out  (a_ser),
        .par_next (a_next_unused)
    );

    master_shift_reg #(.W(BURST_W)) u_burst_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .din      ({burst_len, burst_en}),
        .shift    (burst_win && (state != SPLIT)),
        .ser_in   (1'b0),
        .ser_out  (b_ser),
        .par_next (b_next_unused)
    );

    master_shift_reg #(.W(DATA_W)) u_wdata_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .din      (w_din),
        .shift    (state == WDATA),
        .ser_in   (1'b0),
        .ser_out  (w_ser),
        .par_next (w_next_unused)
    );

    master_shift_reg #(.W(DATA_W)) u_rdata_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (1'b0),
        .din      ('0),
        .shift    (state == RDATA),
        .ser_in   (rx_data),
        .ser_out  (rx_ser_unused),
        .par_next (rx_next)
    );

    // The burst field is one bit longer than the address, so its
    // window runs on its own counter past the end of ADDR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_win <= 1'b0;
            burst_cnt <= '0;
        end else if ((state == HANDSHAKE) && s_ready && !split_enable) begin
            burst_win <= 1'b1;
            burst_cnt <= '0;
        end else if (burst_win && (state != SPLIT)) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == B_LAST) begin
                burst_win <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            beat_cnt     <= '0;
            burst_len_q  <= '0;
            burst_en_q   <= 1'b0;
            wr_q         <= 1'b0;
            wbeat        <= '0;
            m_valid      <= 1'b0;
            m_ready      <= 1'b0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            rdata        <= '0;
            rdata_valid  <= 1'b0;
            wdata_req    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            wdata_req   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        wr_q         <= wr;
                        burst_en_q   <= burst_en;
                        burst_len_q  <= burst_len;
                        wbeat        <= wdata;
                        beat_cnt     <= '0;
                        bit_cnt      <= '0;
                        busy         <= 1'b1;
                        m_valid      <= 1'b1;
                        read_enable  <= ~wr;
                        write_enable <= wr;
                        state        <= HANDSHAKE;
                    end
                end
                HANDSHAKE: begin
                    if (split_enable) begin
                        m_valid <= 1'b0;
                        state   <= SPLIT;
                    end else if (s_ready) begin
                        bit_cnt <= '0;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (split_enable) begin
                        m_valid <= 1'b0;
                        m_ready <= 1'b0;
                        state   <= SPLIT;
                    end else if (bit_cnt == A_LAST) begin
                        bit_cnt <= '0;
                        if (wr_q) begin
                            state <= WDATA;
                        end else begin
                            m_ready <= 1'b1;
                            state   <= RWAIT;
                        end
                    end
                end
                WDATA: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if ((bit_cnt == D_PRE) && !last_b && !split_enable) begin
                        wdata_req <= 1'b1;
                    end
                    if (bit_cnt == D_LAST) begin
                        bit_cnt <= '0;
                        if (last_b) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            wbeat    <= wdata;
                            if (split_enable) begin
                                m_valid <= 1'b0;
                                state   <= SPLIT;
                            end
                        end
                    end else if (split_enable) begin
                        m_valid <= 1'b0;
                        state   <= SPLIT;
                    end
                end
                RWAIT: begin
                    if (split_enable) begin
                        m_valid <= 1'b0;
                        m_ready <= 1'b0;
                        state   <= SPLIT;
                    end else if (s_valid) begin
                        bit_cnt <= '0;
                        state   <= RDATA;
                    end
                end
                RDATA: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == D_LAST) begin
                        bit_cnt     <= '0;
                        rdata       <= rx_next;
                        rdata_valid <= 1'b1;
                        if (last_b) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (split_enable) begin
                                m_valid <= 1'b0;
                                m_ready <= 1'b0;
                                state   <= SPLIT;
                            end else begin
                                state <= RWAIT;
                            end
                        end
                    end else if (split_enable) begin
                        m_valid <= 1'b0;
                        m_ready <= 1'b0;
                        state   <= SPLIT;
                    end
                end
                SPLIT: begin
                    // Resume on a beat boundary; the interrupted beat replays.
                    if (!split_enable) begin
                        m_valid <= 1'b1;
                        bit_cnt <= '0;
                        if (wr_q) begin
                            state <= WDATA;
                        end else begin
                            m_ready <= 1'b1;
                            state   <= RWAIT;
                        end
                    end
                end
                DONE: begin
                    busy         <= 1'b0;
                    m_valid      <= 1'b0;
                    m_ready      <= 1'b0;
                    read_enable  <= 1'b0;
                    write_enable <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
